// File: rtl/store_buffer_pkg.sv
// Shared defaults, buffered-entry type and word-alignment helper for the
// store buffer and its users.
package store_buffer_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

  function automatic logic [SB_AW-1:0] word_align(input logic [SB_AW-1:0] a);
    return {a[SB_AW-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Pipeline-side store/load signals and data-memory write port of the store
// buffer. The buffer is the slave; the pipeline/memory environment is the master.
interface store_buffer_if
  import store_buffer_pkg::*;
#(
  parameter int AW = SB_AW,
  parameter int DW = SB_DW
) ();

  logic          MemWriteM;
  logic          MemReadM;
  logic [AW-1:0] ALUResultM;
  logic [DW-1:0] WriteDataM;
  logic          StallSB;
  logic          FwdHitM;
  logic [DW-1:0] FwdDataM;
  logic          MemWReq;
  logic [AW-1:0] MemWAddr;
  logic [DW-1:0] MemWData;
  logic          MemWAck;
  logic          SBEmpty;

  modport slave (
    input  MemWriteM, MemReadM, ALUResultM, WriteDataM, MemWAck,
    output StallSB, FwdHitM, FwdDataM, MemWReq, MemWAddr, MemWData, SBEmpty
  );

  modport master (
    output MemWriteM, MemReadM, ALUResultM, WriteDataM, MemWAck,
    input  StallSB, FwdHitM, FwdDataM, MemWReq, MemWAddr, MemWData, SBEmpty
  );

endinterface

// File: rtl/store_buffer_fwd_match.sv
// Youngest-match search for load forwarding: walks the entries from oldest
// (head) to youngest so the last hit wins.
module sb_fwd_match #(
  parameter  int DEPTH = 4,
  parameter  int AW    = 32,
  parameter  int DW    = 32,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic             lookup_en_i,
  input  logic [AW-1:0]    lookup_addr_i,
  input  logic [PW-1:0]    head_i,
  input  logic [DEPTH-1:0] valid_i,
  input  logic [AW-1:0]    addr_i [DEPTH],
  input  logic [DW-1:0]    data_i [DEPTH],
  output logic             hit_o,
  output logic [DW-1:0]    data_o
);

  logic [PW-1:0] idx;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; otherwise a latch is inferred.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = head_i;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PW'(k);
      if (lookup_en_i && valid_i[idx] && (addr_i[idx] == lookup_addr_i)) begin
        hit_o  = 1'b1;
        data_o = data_i[idx];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Circular write buffer between the memory stage and the data-memory write
// port: queues word stores, drains them in order over req/ack, forwards to loads.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic           clk,
  input  logic           reset,
  store_buffer_if.slave  sb
);

  localparam int              PW        = $clog2(DEPTH);
  localparam int              CW        = PW + 1;
  localparam logic [CW-1:0]   FULL      = CW'(DEPTH);
  localparam logic [AW-1:0]   WORD_MASK = ~AW'(3);

  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];

  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic [AW-1:0] word_addr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL);
  assign word_addr = sb.ALUResultM & WORD_MASK;

  // A full buffer refuses the store even if the head is acked this cycle.
  assign push = sb.MemWriteM && !full;
  assign pop  = sb.MemWAck && !empty;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // NOTE: entry storage is deliberately not reset; every read of it is
  // qualified by count/valid, which are.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= word_addr;
      data_q[tail_q] <= sb.WriteDataM;
    end
  end

  sb_fwd_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fwd_match (
    .lookup_en_i   (sb.MemReadM),
    .lookup_addr_i (word_addr),
    .head_i        (head_q),
    .valid_i       (valid_q),
    .addr_i        (addr_q),
    .data_i        (data_q),
    .hit_o         (fwd_hit),
    .data_o        (fwd_data)
  );

  assign sb.StallSB  = sb.MemWriteM && full;
  assign sb.MemWReq  = !empty;
  assign sb.MemWAddr = empty ? '0 : addr_q[head_q];
  assign sb.MemWData = empty ? '0 : data_q[head_q];
  assign sb.SBEmpty  = empty;
  assign sb.FwdHitM  = fwd_hit;
  assign sb.FwdDataM = fwd_data;

  a_count_bound: assert property (@(posedge clk) disable iff (reset) count_q <= FULL);

endmodule

// File: tb/tb_store_buffer.sv
// Scenario bench for store_buffer: directed cases plus randomized traffic
// checked against a queue model of the buffer.
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int DEPTH = SB_DEPTH;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  store_buffer_if #(.AW(SB_AW), .DW(SB_DW)) sb_if ();

  store_buffer #(.DEPTH(DEPTH), .AW(SB_AW), .DW(SB_DW)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb_if)
  );

  always #5 clk = ~clk;

  task automatic set_in(input logic wr, input logic rd, input logic [SB_AW-1:0] a,
                        input logic [SB_DW-1:0] d, input logic ack);
    sb_if.MemWriteM  = wr;
    sb_if.MemReadM   = rd;
    sb_if.ALUResultM = a;
    sb_if.WriteDataM = d;
    sb_if.MemWAck    = ack;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_in(1'b1, 1'b0, 32'h100, 32'hAA, 1'b0); tick();
    set_in(1'b1, 1'b0, 32'h104, 32'hBB, 1'b0); @(negedge clk);
    checks++; if (sb_if.MemWReq !== 1'b1) begin errors++; $display("FAIL reset_pre_req: got %b expected 1", sb_if.MemWReq); end
    tick();
    reset = 1'b1;
    set_in(1'b1, 1'b0, 32'h108, 32'hCC, 1'b1);
    tick(); tick();
    reset = 1'b0;
    set_in(1'b0, 1'b1, 32'h100, 32'h0, 1'b0); @(negedge clk);
    checks++; if (sb_if.SBEmpty  !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", sb_if.SBEmpty); end
    checks++; if (sb_if.MemWReq  !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", sb_if.MemWReq); end
    checks++; if (sb_if.FwdHitM  !== 1'b0) begin errors++; $display("FAIL reset_fwd_hit: got %b expected 0", sb_if.FwdHitM); end
    checks++; if (sb_if.FwdDataM !== '0)   begin errors++; $display("FAIL reset_fwd_data: got %0h expected 0", sb_if.FwdDataM); end
    checks++; if (sb_if.MemWAddr !== '0)   begin errors++; $display("FAIL reset_waddr: got %0h expected 0", sb_if.MemWAddr); end
    checks++; if (sb_if.MemWData !== '0)   begin errors++; $display("FAIL reset_wdata: got %0h expected 0", sb_if.MemWData); end
    checks++; if (sb_if.StallSB  !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", sb_if.StallSB); end
    tick();
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_single_store();
    set_in(1'b1, 1'b0, 32'd76, 32'd49, 1'b1); @(negedge clk);
    checks++; if (sb_if.MemWReq !== 1'b0) begin errors++; $display("FAIL single_req_before: got %b expected 0", sb_if.MemWReq); end
    tick();
    set_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b1); @(negedge clk);
    checks++; if (sb_if.MemWReq  !== 1'b1)  begin errors++; $display("FAIL single_req: got %b expected 1", sb_if.MemWReq); end
    checks++; if (sb_if.MemWAddr !== 32'd76) begin errors++; $display("FAIL single_waddr: got %0d expected 76", sb_if.MemWAddr); end
    checks++; if (sb_if.MemWData !== 32'd49) begin errors++; $display("FAIL single_wdata: got %0d expected 49", sb_if.MemWData); end
    tick();
    @(negedge clk);
    checks++; if (sb_if.SBEmpty !== 1'b1) begin errors++; $display("FAIL single_empty_after: got %b expected 1", sb_if.SBEmpty); end
    tick();
    set_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic test_full_stall();
    logic [SB_AW-1:0] exp_a;
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, 1'b0, SB_AW'(4 * i), SB_DW'(32'h1000 + i), 1'b0); @(negedge clk);
      checks++; if (sb_if.StallSB !== 1'b0) begin errors++; $display("FAIL full_fill_stall[%0d]: got %b expected 0", i, sb_if.StallSB); end
      tick();
    end
    set_in(1'b1, 1'b0, 32'd16, 32'h1004, 1'b0); @(negedge clk);
    checks++; if (sb_if.StallSB  !== 1'b1)  begin errors++; $display("FAIL full_stall: got %b expected 1", sb_if.StallSB); end
    checks++; if (sb_if.MemWAddr !== 32'd0) begin errors++; $display("FAIL full_head: got %0d expected 0", sb_if.MemWAddr); end
    tick();
    @(negedge clk);
    checks++; if (sb_if.StallSB !== 1'b1) begin errors++; $display("FAIL full_stall_held: got %b expected 1", sb_if.StallSB); end
    tick();
    set_in(1'b1, 1'b0, 32'd16, 32'h1004, 1'b1); @(negedge clk);
    checks++; if (sb_if.StallSB  !== 1'b1)  begin errors++; $display("FAIL full_no_lookahead: got %b expected 1", sb_if.StallSB); end
    checks++; if (sb_if.MemWAddr !== 32'd0) begin errors++; $display("FAIL full_pop_addr: got %0d expected 0", sb_if.MemWAddr); end
    tick();
    set_in(1'b1, 1'b0, 32'd16, 32'h1004, 1'b0); @(negedge clk);
    checks++; if (sb_if.StallSB  !== 1'b0)  begin errors++; $display("FAIL full_accept: got %b expected 0", sb_if.StallSB); end
    checks++; if (sb_if.MemWAddr !== 32'd4) begin errors++; $display("FAIL full_new_head: got %0d expected 4", sb_if.MemWAddr); end
    tick();
    for (int i = 1; i <= DEPTH; i++) begin
      exp_a = SB_AW'(4 * i);
      set_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b1); @(negedge clk);
      checks++; if (sb_if.MemWAddr !== exp_a) begin errors++; $display("FAIL full_drain_addr[%0d]: got %0d expected %0d", i, sb_if.MemWAddr, exp_a); end
      checks++; if (sb_if.MemWData !== SB_DW'(32'h1000 + i)) begin errors++; $display("FAIL full_drain_data[%0d]: got %0h expected %0h", i, sb_if.MemWData, 32'h1000 + i); end
      tick();
    end
    set_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b0); @(negedge clk);
    checks++; if (sb_if.SBEmpty !== 1'b1) begin errors++; $display("FAIL full_drained: got %b expected 1", sb_if.SBEmpty); end
    tick();
  endtask

  task automatic test_forward();
    set_in(1'b1, 1'b0, 32'd76, 32'd49, 1'b0); tick();
    set_in(1'b1, 1'b0, 32'd76, 32'd50, 1'b0); tick();
    set_in(1'b0, 1'b1, 32'd78, 32'd0, 1'b0); @(negedge clk);
    checks++; if (sb_if.FwdHitM  !== 1'b1)  begin errors++; $display("FAIL fwd_hit_78: got %b expected 1", sb_if.FwdHitM); end
    checks++; if (sb_if.FwdDataM !== 32'd50) begin errors++; $display("FAIL fwd_data_78: got %0d expected 50", sb_if.FwdDataM); end
    tick();
    set_in(1'b0, 1'b1, 32'd80, 32'd0, 1'b0); @(negedge clk);
    checks++; if (sb_if.FwdHitM  !== 1'b0) begin errors++; $display("FAIL fwd_miss_80: got %b expected 0", sb_if.FwdHitM); end
    checks++; if (sb_if.FwdDataM !== '0)   begin errors++; $display("FAIL fwd_miss_data: got %0d expected 0", sb_if.FwdDataM); end
    tick();
    set_in(1'b1, 1'b1, 32'd200, 32'd7, 1'b0); @(negedge clk);
    checks++; if (sb_if.FwdHitM !== 1'b0) begin errors++; $display("FAIL fwd_same_cycle_push: got %b expected 0", sb_if.FwdHitM); end
    tick();
    set_in(1'b0, 1'b1, 32'd76, 32'd0, 1'b1); @(negedge clk);
    checks++; if (sb_if.FwdDataM !== 32'd50) begin errors++; $display("FAIL fwd_during_pop: got %0d expected 50", sb_if.FwdDataM); end
    tick();
    @(negedge clk);
    checks++; if (sb_if.FwdDataM !== 32'd50) begin errors++; $display("FAIL fwd_popping_entry: got %0d expected 50", sb_if.FwdDataM); end
    tick();
    set_in(1'b0, 1'b1, 32'd201, 32'd0, 1'b1); @(negedge clk);
    checks++; if (sb_if.FwdHitM  !== 1'b1) begin errors++; $display("FAIL fwd_hit_200: got %b expected 1", sb_if.FwdHitM); end
    checks++; if (sb_if.FwdDataM !== 32'd7) begin errors++; $display("FAIL fwd_data_200: got %0d expected 7", sb_if.FwdDataM); end
    tick();
    set_in(1'b0, 1'b1, 32'd200, 32'd0, 1'b0); @(negedge clk);
    checks++; if (sb_if.FwdHitM !== 1'b0) begin errors++; $display("FAIL fwd_after_drain: got %b expected 0", sb_if.FwdHitM); end
    tick();
    set_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic test_push_pop();
    set_in(1'b1, 1'b0, 32'd8, 32'h55, 1'b0); tick();
    set_in(1'b1, 1'b0, 32'd20, 32'h66, 1'b1); @(negedge clk);
    checks++; if (sb_if.MemWAddr !== 32'd8) begin errors++; $display("FAIL pp_head_before: got %0d expected 8", sb_if.MemWAddr); end
    tick();
    set_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b0); @(negedge clk);
    checks++; if (sb_if.MemWReq  !== 1'b1)   begin errors++; $display("FAIL pp_no_bubble: got %b expected 1", sb_if.MemWReq); end
    checks++; if (sb_if.MemWAddr !== 32'd20)  begin errors++; $display("FAIL pp_new_head: got %0d expected 20", sb_if.MemWAddr); end
    checks++; if (sb_if.MemWData !== 32'h66)  begin errors++; $display("FAIL pp_new_data: got %0h expected 66", sb_if.MemWData); end
    tick();
    set_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b1); tick();
    set_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b0); @(negedge clk);
    checks++; if (sb_if.SBEmpty !== 1'b1) begin errors++; $display("FAIL pp_count_one: got %b expected 1", sb_if.SBEmpty); end
    tick();
  endtask

  task automatic test_random(input int n);
    sb_entry_t        model_q[$];
    logic             wr, rd, ack, exp_hit, exp_stall, exp_req;
    logic [SB_AW-1:0] a, exp_waddr;
    logic [SB_DW-1:0] d, exp_fwd, exp_wdata;
    int               sz;
    for (int c = 0; c < n; c++) begin
      wr  = ($urandom_range(0, 99) < 55);
      rd  = ($urandom_range(0, 99) < 50);
      ack = ($urandom_range(0, 99) < 45);
      a   = 32'h400 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
      d   = $urandom;
      set_in(wr, rd, a, d, ack);
      @(negedge clk);
      sz        = model_q.size();
      exp_stall = wr && (sz == DEPTH);
      exp_req   = (sz != 0);
      exp_waddr = exp_req ? model_q[0].addr : '0;
      exp_wdata = exp_req ? model_q[0].data : '0;
      exp_hit   = 1'b0;
      exp_fwd   = '0;
      if (rd) begin
        foreach (model_q[i]) begin
          if (model_q[i].addr == word_align(a)) begin
            exp_hit = 1'b1;
            exp_fwd = model_q[i].data;
          end
        end
      end
      checks++; if (sb_if.StallSB  !== exp_stall) begin errors++; $display("FAIL rnd_stall c=%0d: got %b expected %b", c, sb_if.StallSB, exp_stall); end
      checks++; if (sb_if.MemWReq  !== exp_req)   begin errors++; $display("FAIL rnd_req c=%0d: got %b expected %b", c, sb_if.MemWReq, exp_req); end
      checks++; if (sb_if.SBEmpty  !== !exp_req)  begin errors++; $display("FAIL rnd_empty c=%0d: got %b expected %b", c, sb_if.SBEmpty, !exp_req); end
      checks++; if (sb_if.MemWAddr !== exp_waddr) begin errors++; $display("FAIL rnd_waddr c=%0d: got %0h expected %0h", c, sb_if.MemWAddr, exp_waddr); end
      checks++; if (sb_if.MemWData !== exp_wdata) begin errors++; $display("FAIL rnd_wdata c=%0d: got %0h expected %0h", c, sb_if.MemWData, exp_wdata); end
      checks++; if (sb_if.FwdHitM  !== exp_hit)   begin errors++; $display("FAIL rnd_fwd_hit c=%0d: got %b expected %b", c, sb_if.FwdHitM, exp_hit); end
      checks++; if (sb_if.FwdDataM !== exp_fwd)   begin errors++; $display("FAIL rnd_fwd_data c=%0d: got %0h expected %0h", c, sb_if.FwdDataM, exp_fwd); end
      tick();
      if (ack && sz > 0) void'(model_q.pop_front());
      if (wr && sz < DEPTH) model_q.push_back('{addr: word_align(a), data: d});
    end
    // Drain what is left and confirm the buffer empties within DEPTH cycles.
    for (int k = 0; k < DEPTH + 2; k++) begin
      set_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      @(negedge clk);
      if (model_q.size() != 0) begin
        checks++; if (sb_if.MemWAddr !== model_q[0].addr) begin errors++; $display("FAIL rnd_drain_addr k=%0d: got %0h expected %0h", k, sb_if.MemWAddr, model_q[0].addr); end
        void'(model_q.pop_front());
      end
      tick();
    end
    set_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    checks++; if (sb_if.SBEmpty !== 1'b1) begin errors++; $display("FAIL rnd_final_empty: got %b expected 1", sb_if.SBEmpty); end
    tick();
  endtask

  initial begin
    reset = 1'b1;
    set_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_single_store();
    test_full_stall();
    test_forward();
    test_push_pop();
    test_random(10000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
